// File: rtl/led_chaser_fader_if.sv
// Control and drive bundle for led_chaser_fader.
//   master : speed, mode, tail_en, invert out; led_out, pos, step in
//   slave  : the chaser itself (inputs and outputs reversed)
// Field widths follow NUM_LEDS and SPEED_WIDTH. pos is wide enough to index
// NUM_LEDS channels, never narrower than one bit.
interface led_chaser_fader_if #(
   parameter int NUM_LEDS    = 8,
   parameter int SPEED_WIDTH = 3
);
   localparam int POS_W = $clog2((NUM_LEDS > 2) ? NUM_LEDS : 2);

   logic [SPEED_WIDTH-1:0] speed;
   logic [1:0]             mode;
   logic                   tail_en;
   logic                   invert;
   logic [NUM_LEDS-1:0]    led_out;
   logic [POS_W-1:0]       pos;
   logic                   step;

   modport master (
      output speed, mode, tail_en, invert,
      input  led_out, pos, step
   );

   modport slave (
      input  speed, mode, tail_en, invert,
      output led_out, pos, step
   );
endinterface

// File: rtl/led_chaser_fader.sv
// LED chaser with PWM fading tail.
// One active channel walks across NUM_LEDS outputs. Channels it leaves behind
// decay by halving brightness on every decay tick, and each channel's
// brightness drives its own PWM comparator.
//   clk    : single clock, rising edge
//   reset  : synchronous, active high
//   bus    : slave side of led_chaser_fader_if
//            speed   step period prefix (larger = slower)
//            mode    00 fwd-wrap, 01 rev-wrap, 10 bounce, 11 hold
//            tail_en 1 = non-active channels decay, 0 = they go dark
//            invert  XOR applied to every led_out bit
//            led_out PWM drive, pos active channel, step strobe per prescaler wrap
//
// Bounce direction state:
//   state    | meaning
//   DIR_UP   | bounce walks toward NUM_LEDS-1 (reset state)
//   DIR_DOWN | bounce walks toward 0
module led_chaser_fader #(
   parameter int NUM_LEDS       = 8,
   parameter int FADE_WIDTH     = 4,
   parameter int PRESCALE_WIDTH = 11,
   parameter int SPEED_WIDTH    = 3,
   parameter int DECAY_WIDTH    = 10
) (
   input logic               clk,
   input logic               reset,
   led_chaser_fader_if.slave bus
);
   localparam int POS_W = $clog2((NUM_LEDS > 2) ? NUM_LEDS : 2);
   localparam int EXT_W = PRESCALE_WIDTH - SPEED_WIDTH;
   localparam logic [POS_W-1:0] LAST = POS_W'(NUM_LEDS - 1);

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
   logic [DECAY_WIDTH-1:0]    dcnt_q, dcnt_d;
   logic [FADE_WIDTH-1:0]     wcnt_q, wcnt_d;
   logic [POS_W-1:0]          pos_q, pos_d;
   dir_e                      dir_q, dir_d;
   logic                      step_q, step_d;
   logic [NUM_LEDS-1:0]       led_r_q, led_r_d;
   logic [FADE_WIDTH-1:0]     bright_q [NUM_LEDS];
   logic [FADE_WIDTH-1:0]     bright_d [NUM_LEDS];
   logic [PRESCALE_WIDTH-1:0] limit;

   // Low bits forced to ones so speed=0 still gives a period of 2^EXT_W.
   assign limit = {bus.speed, {EXT_W{1'b1}}};

   // Prescaler, position walk and bounce direction.
   // The >= compare lets a speed decrease mid-count fire on the next cycle.
   always_comb begin
      pcnt_d = pcnt_q + 1'b1;
      step_d = 1'b0;
      pos_d  = pos_q;
      dir_d  = dir_q;
      dcnt_d = dcnt_q + 1'b1;
      wcnt_d = wcnt_q + 1'b1;

      if (pcnt_q >= limit) begin
         pcnt_d = '0;
         step_d = 1'b1;
         if (NUM_LEDS > 1) begin
            unique case (bus.mode)
               2'b00: pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
               2'b01: pos_d = (pos_q == '0) ? LAST : pos_q - 1'b1;
               2'b10: begin
                  if (dir_q == DIR_UP) begin
                     if (pos_q == LAST) begin
                        dir_d = DIR_DOWN;
                        pos_d = pos_q - 1'b1;
                     end else begin
                        pos_d = pos_q + 1'b1;
                     end
                  end else begin
                     if (pos_q == '0) begin
                        dir_d = DIR_UP;
                        pos_d = POS_W'(1);
                     end else begin
                        pos_d = pos_q - 1'b1;
                     end
                  end
               end
               default: pos_d = pos_q;
            endcase
         end
      end
   end

   // Brightness and PWM compare. Both look at the registered pos, so the
   // channel just left on a step still counts as active for that edge.
   always_comb begin
      for (int i = 0; i < NUM_LEDS; i++) begin
         bright_d[i] = bright_q[i];
         if (POS_W'(i) == pos_q) begin
            bright_d[i] = '1;
         end else if (!bus.tail_en) begin
            bright_d[i] = '0;
         end else if (dcnt_q == '0) begin
            bright_d[i] = bright_q[i] >> 1;
         end
         led_r_d[i] = (bright_q[i] > wcnt_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt_q   <= '0;
         dcnt_q   <= '0;
         wcnt_q   <= '0;
         pos_q    <= '0;
         dir_q    <= DIR_UP;
         step_q   <= 1'b0;
         led_r_q  <= '0;
         bright_q <= '{default: '0};
      end else begin
         pcnt_q   <= pcnt_d;
         dcnt_q   <= dcnt_d;
         wcnt_q   <= wcnt_d;
         pos_q    <= pos_d;
         dir_q    <= dir_d;
         step_q   <= step_d;
         led_r_q  <= led_r_d;
         bright_q <= bright_d;
      end
   end

   assign bus.led_out = led_r_q ^ {NUM_LEDS{bus.invert}};
   assign bus.pos     = pos_q;
   assign bus.step    = step_q;
endmodule

// File: tb/tb_led_chaser_fader.sv
module tb_led_chaser_fader;
   localparam int N  = 4;
   localparam int FW = 4;
   localparam int PW = 4;
   localparam int SW = 2;
   localparam int DW = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   led_chaser_fader_if #(.NUM_LEDS(N), .SPEED_WIDTH(SW)) bif ();

   led_chaser_fader #(
      .NUM_LEDS(N), .FADE_WIDTH(FW), .PRESCALE_WIDTH(PW),
      .SPEED_WIDTH(SW), .DECAY_WIDTH(DW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bif)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int m_pcnt, m_dcnt, m_wcnt, m_pos, m_step;
   bit m_dir_up;
   int m_bright [N];
   int m_led    [N];

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic int exp_led_out();
      int v = 0;
      for (int i = 0; i < N; i++) if (m_led[i] != 0) v |= (1 << i);
      if (bif.invert) v ^= (1 << N) - 1;
      return v;
   endfunction

   // One clock of the behavioural model, using the inputs present at the edge.
   task automatic model_step();
      int limit, np;
      int nb [N];
      int nl [N];
      if (reset) begin
         m_pcnt = 0; m_dcnt = 0; m_wcnt = 0; m_pos = 0; m_step = 0; m_dir_up = 1;
         for (int i = 0; i < N; i++) begin m_bright[i] = 0; m_led[i] = 0; end
         return;
      end
      limit = (int'(bif.speed) + 1) * (1 << (PW - SW)) - 1;
      for (int i = 0; i < N; i++) begin
         nl[i] = (m_bright[i] > m_wcnt) ? 1 : 0;
         if (i == m_pos)            nb[i] = (1 << FW) - 1;
         else if (!bif.tail_en)     nb[i] = 0;
         else if (m_dcnt == 0)      nb[i] = m_bright[i] / 2;
         else                       nb[i] = m_bright[i];
      end
      np = m_pos;
      if (m_pcnt >= limit) begin
         m_pcnt = 0;
         m_step = 1;
         if (N > 1) begin
            case (bif.mode)
               2'd0: np = (m_pos + 1) % N;
               2'd1: np = (m_pos + N - 1) % N;
               2'd2: begin
                  if (m_dir_up && m_pos == N - 1)  begin m_dir_up = 0; np = m_pos - 1; end
                  else if (!m_dir_up && m_pos == 0) begin m_dir_up = 1; np = 1; end
                  else np = m_dir_up ? m_pos + 1 : m_pos - 1;
               end
               default: np = m_pos;
            endcase
         end
      end else begin
         m_pcnt = m_pcnt + 1;
         m_step = 0;
      end
      m_pos    = np;
      m_bright = nb;
      m_led    = nl;
      m_dcnt   = (m_dcnt + 1) % (1 << DW);
      m_wcnt   = (m_wcnt + 1) % (1 << FW);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_val("led_out", bif.led_out, exp_led_out());
      check_val("pos", bif.pos, m_pos);
      check_val("step", bif.step, m_step);
   endtask

   task automatic do_reset(input int cycles, input bit inv);
      reset = 1'b1;
      bif.invert = inv;
      repeat (cycles) begin
         tick();
         check_val("rst_led_out", bif.led_out, inv ? (1 << N) - 1 : 0);
         check_val("rst_pos", bif.pos, 0);
         check_val("rst_step", bif.step, 0);
      end
      reset = 1'b0;
   endtask

   task automatic wait_step(output int cycles);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!bif.step && n < 200);
      if (!bif.step) check_val("step_timeout", 0, 1);
      cycles = n;
   endtask

   initial begin
      int c, hi, other;
      int bseq [7] = '{0, 1, 2, 3, 2, 1, 0};
      int rseq [3] = '{3, 2, 1};
      int fseq [4] = '{1, 2, 3, 0};

      reset = 1'b1;
      bif.speed = '0; bif.mode = 2'b00; bif.tail_en = 1'b1; bif.invert = 1'b0;

      // reset with both invert polarities
      do_reset(3, 1'b0);
      do_reset(3, 1'b1);
      bif.invert = 1'b0;

      // forward period and sequence, then slower speed
      do_reset(2, 1'b0);
      for (int k = 0; k < 4; k++) begin
         wait_step(c);
         check_val("fwd_period", c, 4);
         check_val("fwd_pos", bif.pos, fseq[k]);
      end
      bif.speed = 2'd1;
      repeat (2) begin
         wait_step(c);
         check_val("fwd_period_speed1", c, 8);
      end

      // bounce from reset, then reverse, then hold
      bif.speed = '0; bif.mode = 2'b10;
      do_reset(2, 1'b0);
      check_val("bounce_start", bif.pos, 0);
      for (int k = 1; k < 7; k++) begin
         wait_step(c);
         check_val("bounce_pos", bif.pos, bseq[k]);
      end
      bif.mode = 2'b01;
      for (int k = 0; k < 3; k++) begin
         wait_step(c);
         check_val("rev_pos", bif.pos, rseq[k]);
      end
      bif.mode = 2'b11;
      for (int k = 0; k < 3; k++) begin
         wait_step(c);
         check_val("hold_period", c, 4);
         check_val("hold_pos", bif.pos, 1);
      end

      // PWM duty of the active channel, no tail
      bif.tail_en = 1'b0;
      do_reset(2, 1'b0);
      repeat (3) tick();
      hi = 0; other = 0;
      repeat (16) begin
         tick();
         hi += int'(bif.led_out[0]);
         other |= int'(bif.led_out[N-1:1]);
      end
      check_val("duty_full", hi, 15);
      check_val("duty_others", other, 0);
      bif.invert = 1'b1;
      hi = 0;
      repeat (16) begin tick(); hi += int'(bif.led_out[0]); end
      check_val("duty_inverted", hi, 1);
      bif.invert = 1'b0;

      // tail decays to dark; dropping tail_en clears it; speed drop
      bif.mode = 2'b00; bif.speed = 2'd3; bif.tail_en = 1'b1;
      do_reset(2, 1'b0);
      wait_step(c);
      check_val("tail_pos", bif.pos, 1);
      repeat (20) tick();
      check_val("tail_dark", bif.led_out[0], 0);
      wait_step(c);
      bif.tail_en = 1'b0;
      repeat (2) tick();
      check_val("tail_drop", int'(bif.led_out) & ~(1 << bif.pos), 0);
      bif.tail_en = 1'b1;
      wait_step(c);
      repeat (6) tick();
      bif.speed = '0;
      tick();
      check_val("speed_drop_step", bif.step, 1);

      // reset in the middle of a downward bounce
      bif.mode = 2'b10;
      do_reset(1, 1'b0);
      repeat (4) wait_step(c);
      check_val("mid_bounce_pos", bif.pos, 2);
      do_reset(2, 1'b0);
      wait_step(c);
      check_val("restart_pos1", bif.pos, 1);
      wait_step(c);
      check_val("restart_pos2", bif.pos, 2);

      // randomized segments against the model
      for (int seg = 0; seg < 150; seg++) begin
         bif.speed   = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, 3)) : SW'($urandom_range(0, 1));
         bif.mode    = 2'($urandom_range(0, 3));
         bif.tail_en = 1'($urandom_range(0, 3) != 0);
         bif.invert  = 1'($urandom_range(0, 1));
         reset       = ($urandom_range(0, 19) == 0);
         repeat ($urandom_range(1, 40)) tick();
      end
      reset = 1'b0;
      repeat (8) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
